// File: rtl/ysyx_24100005_lsu.sv
// Non-pipelined load/store unit: execute-stage request -> valid/ready data bus -> extended response.
// Optional macro YSYX_24100005_LSU_MISALIGN_TRAP_EN turns misaligned accesses into error responses.
module ysyx_24100005_lsu #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                resp_err,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wmask,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_WAIT, S_RESP} state_e;

    function automatic logic is_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b011:                 ok = (XLEN == 64);
            3'b100, 3'b101:         ok = !we;
            3'b110:                 ok = !we && (XLEN == 64);
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Offset bits that must be zero for an access of this size.
    function automatic logic [OFF_W-1:0] low_mask(input logic [1:0] sz);
        logic [2:0] m;
        case (sz)
            2'd0:    m = 3'd0;
            2'd1:    m = 3'd1;
            2'd2:    m = 3'd3;
            default: m = 3'd7;
        endcase
        return OFF_W'(m);
    endfunction

    function automatic logic [NB-1:0] size_mask(input logic [1:0] sz);
        logic [7:0] m;
        case (sz)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return NB'(m);
    endfunction

    function automatic logic [XLEN-1:0] ext_load(input logic [2:0] f3, input logic [XLEN-1:0] d);
        logic [XLEN-1:0] r;
        case (f3)
            3'b000:  r = XLEN'($signed(d[7:0]));
            3'b001:  r = XLEN'($signed(d[15:0]));
            3'b010:  r = XLEN'($signed(d[31:0]));
            3'b100:  r = XLEN'(d[7:0]);
            3'b101:  r = XLEN'(d[15:0]);
            3'b110:  r = XLEN'(d[31:0]);
            default: r = d;
        endcase
        return r;
    endfunction

    state_e             state_q;
    logic               req_ready_q, resp_valid_q, resp_err_q, mem_valid_q, mem_we_q;
    logic [XLEN-1:0]    resp_rdata_q, mem_wdata_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [NB-1:0]      mem_wmask_q;
    logic [OFF_W-1:0]   off_q;
    logic [2:0]         f3_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [OFF_W-1:0]   lmask_d, off_raw_d, off_d;
    logic               fail_d, timeout_d;
    logic [ADDR_W-1:0]  lane_addr_d;
    logic [NB-1:0]      wmask_d;
    logic [XLEN-1:0]    wdata_d, rdata_d;

    always_comb begin
        lmask_d     = low_mask(req_funct3[1:0]);
        off_raw_d   = req_addr[OFF_W-1:0];
`ifdef YSYX_24100005_LSU_MISALIGN_TRAP_EN
        off_d       = off_raw_d;
        fail_d      = !is_legal(req_we, req_funct3) || (|(off_raw_d & lmask_d));
`else
        off_d       = off_raw_d & ~lmask_d;
        fail_d      = !is_legal(req_we, req_funct3);
`endif
        lane_addr_d = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        wmask_d     = req_we ? (size_mask(req_funct3[1:0]) << off_d) : '0;
        wdata_d     = req_wdata << {off_d, 3'b000};
        rdata_d     = ext_load(f3_q, mem_rdata >> {off_q, 3'b000});
        timeout_d   = (TIMEOUT_CYC != 0) && (cnt_q == TO_LIM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wmask_q  <= '0;
            off_q        <= '0;
            f3_q         <= '0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (req_valid) begin
                    req_ready_q <= 1'b0;
                    cnt_q       <= '0;
                    if (fail_d) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= '0;
                    end else begin
                        state_q     <= S_BUS;
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= req_we;
                        mem_addr_q  <= lane_addr_d;
                        mem_wdata_q <= wdata_d;
                        mem_wmask_q <= wmask_d;
                        off_q       <= off_d;
                        f3_q        <= req_funct3;
                    end
                end
                S_BUS: if (mem_ready) begin
                    state_q     <= S_WAIT;
                    mem_valid_q <= 1'b0;
                    cnt_q       <= cnt_q + CNT_W'(1);
                end else if (timeout_d) begin
                    state_q      <= S_RESP;
                    mem_valid_q  <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b1;
                    resp_rdata_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                // Stores complete on the same acknowledge but return zero data.
                S_WAIT: if (mem_rvalid) begin
                    state_q      <= S_RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= mem_we_q ? '0 : rdata_d;
                end else if (timeout_d) begin
                    state_q      <= S_RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b1;
                    resp_rdata_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                S_RESP: if (resp_ready) begin
                    state_q      <= S_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                    req_ready_q  <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_valid  = mem_valid_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wmask  = mem_wmask_q;
endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// Directed bench for ysyx_24100005_lsu: a 32-bit instance (TIMEOUT_CYC=4) and a 64-bit instance share stimulus.
module tb_ysyx_24100005_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_32, req_valid_64, req_we, resp_ready, mem_ready, mem_rvalid;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [63:0] req_wdata, mem_rdata;

    logic        req_ready_32, resp_valid_32, resp_err_32, mem_valid_32, mem_we_32;
    logic [31:0] resp_rdata_32, mem_addr_32, mem_wdata_32;
    logic [3:0]  mem_wmask_32;
    logic        req_ready_64, resp_valid_64, resp_err_64, mem_valid_64, mem_we_64;
    logic [63:0] resp_rdata_64, mem_wdata_64;
    logic [31:0] mem_addr_64;
    logic [7:0]  mem_wmask_64;

    always #5 clk = ~clk;

    ysyx_24100005_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYC(4)) dut32 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_32), .req_ready(req_ready_32), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .resp_valid(resp_valid_32), .resp_ready(resp_ready), .resp_rdata(resp_rdata_32),
        .resp_err(resp_err_32), .mem_valid(mem_valid_32), .mem_ready(mem_ready),
        .mem_addr(mem_addr_32), .mem_we(mem_we_32), .mem_wdata(mem_wdata_32),
        .mem_wmask(mem_wmask_32), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0])
    );

    ysyx_24100005_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT_CYC(16)) dut64 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_64), .req_ready(req_ready_64), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_64), .resp_ready(resp_ready), .resp_rdata(resp_rdata_64),
        .resp_err(resp_err_64), .mem_valid(mem_valid_64), .mem_ready(mem_ready),
        .mem_addr(mem_addr_64), .mem_we(mem_we_64), .mem_wdata(mem_wdata_64),
        .mem_wmask(mem_wmask_64), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    // Observed view of whichever instance the current step targets.
    logic        sel;
    logic        o_req_ready, o_resp_valid, o_resp_err, o_mem_valid, o_mem_we;
    logic [63:0] o_resp_rdata, o_mem_wdata;
    logic [31:0] o_mem_addr;
    logic [7:0]  o_mem_wmask;
    always_comb begin
        o_req_ready  = sel ? req_ready_64  : req_ready_32;
        o_resp_valid = sel ? resp_valid_64 : resp_valid_32;
        o_resp_err   = sel ? resp_err_64   : resp_err_32;
        o_mem_valid  = sel ? mem_valid_64  : mem_valid_32;
        o_mem_we     = sel ? mem_we_64     : mem_we_32;
        o_resp_rdata = sel ? resp_rdata_64 : {32'h0, resp_rdata_32};
        o_mem_wdata  = sel ? mem_wdata_64  : {32'h0, mem_wdata_32};
        o_mem_addr   = sel ? mem_addr_64   : mem_addr_32;
        o_mem_wmask  = sel ? mem_wmask_64  : {4'h0, mem_wmask_32};
    end

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input string what, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic respond(input string tag, input int hold);
        exp_t e;
        int n;
        n = 0;
        while (o_resp_valid !== 1'b1 && n < 16) begin
            step();
            n++;
        end
        chk(tag, "extra_latency", 64'(n), 64'd0);
        e = sb.pop_front();
        for (int k = 0; k < hold; k++) begin
            mem_rdata = 64'(k) * 64'h0101_0101_0101_0101;
            chk(tag, "hold_valid", 64'(o_resp_valid), 64'd1);
            chk(tag, "hold_rdata", o_resp_rdata, e.rdata);
            step();
        end
        chk(tag, "resp_valid", 64'(o_resp_valid), 64'd1);
        chk(tag, "rdata", o_resp_rdata, e.rdata);
        chk(tag, "err", 64'(o_resp_err), 64'(e.err));
        chk(tag, "mem_valid_resp", 64'(o_mem_valid), 64'd0);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk(tag, "resp_done", 64'(o_resp_valid), 64'd0);
        chk(tag, "ready_back", 64'(o_req_ready), 64'd1);
    endtask

    task automatic xact(input string tag, input logic w64, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                        input logic bypass, input logic dual, input int hold,
                        input logic [31:0] e_addr, input logic [7:0] e_mask, input logic [63:0] e_wdata,
                        input logic [63:0] e_rdata, input logic e_err);
        exp_t e;
        sel = w64;
        #0;
        chk(tag, "req_ready", 64'(o_req_ready), 64'd1);
        e.rdata = e_rdata;
        e.err   = e_err;
        sb.push_back(e);
        if (w64) req_valid_64 = 1'b1;
        else     req_valid_32 = 1'b1;
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        step();
        req_valid_32 = 1'b0;
        req_valid_64 = 1'b0;
        chk(tag, "busy", 64'(o_req_ready), 64'd0);
        if (bypass) begin
            chk(tag, "no_bus", 64'(o_mem_valid), 64'd0);
        end else begin
            chk(tag, "mem_valid", 64'(o_mem_valid), 64'd1);
            chk(tag, "mem_we", 64'(o_mem_we), 64'(we));
            chk(tag, "mem_addr", 64'(o_mem_addr), 64'(e_addr));
            chk(tag, "mem_wmask", 64'(o_mem_wmask), 64'(e_mask));
            chk(tag, "mem_wdata", o_mem_wdata, e_wdata);
            mem_ready = 1'b1;
            if (dual) begin
                mem_rvalid = 1'b1;
                mem_rdata  = ~rd;
            end
            step();
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            chk(tag, "mem_valid_wait", 64'(o_mem_valid), 64'd0);
            mem_rvalid = 1'b1;
            mem_rdata  = rd;
            step();
            mem_rvalid = 1'b0;
        end
        respond(tag, hold);
    endtask

    initial begin
        sel = 1'b0;
        rst = 1'b1;
        req_valid_32 = 1'b0; req_valid_64 = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 64'h0; resp_ready = 1'b0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'h0;
        repeat (2) step();
        chk("reset", "req_ready", 64'(o_req_ready), 64'd1);
        chk("reset", "resp_valid", 64'(o_resp_valid), 64'd0);
        chk("reset", "resp_err", 64'(o_resp_err), 64'd0);
        chk("reset", "resp_rdata", o_resp_rdata, 64'd0);
        chk("reset", "mem_valid", 64'(o_mem_valid), 64'd0);
        chk("reset", "mem_we", 64'(o_mem_we), 64'd0);
        chk("reset", "mem_addr", 64'(o_mem_addr), 64'd0);
        chk("reset", "mem_wdata", o_mem_wdata, 64'd0);
        chk("reset", "mem_wmask", 64'(o_mem_wmask), 64'd0);
        rst = 1'b0;

        //   tag       w64   we    f3      addr           wdata                  mem_rdata              byp   dual  hold e_addr         e_mask  e_wdata                e_rdata                e_err
        xact("lb",     1'b0, 1'b0, 3'b000, 32'h8000_0003, 64'h0,                 64'h80AB_CDEF,         1'b0, 1'b0, 0, 32'h8000_0000, 8'h00, 64'h0,                  64'hFFFF_FF80,         1'b0);
        xact("sh",     1'b0, 1'b1, 3'b001, 32'h8000_0002, 64'h1234_5678,         64'hFFFF_FFFF,         1'b0, 1'b0, 0, 32'h8000_0000, 8'h0C, 64'h5678_0000,          64'h0,                 1'b0);
        xact("sb",     1'b0, 1'b1, 3'b000, 32'h8000_0001, 64'h0000_00AB,         64'h1234_5678,         1'b0, 1'b0, 0, 32'h8000_0000, 8'h02, 64'h0000_AB00,          64'h0,                 1'b0);
        xact("sw",     1'b0, 1'b1, 3'b010, 32'h8000_0004, 64'hCAFE_F00D,         64'h0,                 1'b0, 1'b0, 0, 32'h8000_0004, 8'h0F, 64'hCAFE_F00D,          64'h0,                 1'b0);
        xact("lh",     1'b0, 1'b0, 3'b001, 32'h8000_0002, 64'h0,                 64'h8001_0000,         1'b0, 1'b0, 0, 32'h8000_0000, 8'h00, 64'h0,                  64'hFFFF_8001,         1'b0);
        xact("lbu",    1'b0, 1'b0, 3'b100, 32'h8000_0001, 64'h0,                 64'h0000_9A00,         1'b0, 1'b0, 3, 32'h8000_0000, 8'h00, 64'h0,                  64'h0000_009A,         1'b0);
        xact("dual",   1'b0, 1'b0, 3'b010, 32'h8000_0008, 64'h0,                 64'h0BAD_F00D,         1'b0, 1'b1, 0, 32'h8000_0008, 8'h00, 64'h0,                  64'h0BAD_F00D,         1'b0);
        xact("ill_ld", 1'b0, 1'b0, 3'b111, 32'h8000_0000, 64'h0,                 64'h0,                 1'b1, 1'b0, 0, 32'h0,         8'h00, 64'h0,                  64'h0,                 1'b1);
        xact("ill_st", 1'b0, 1'b1, 3'b100, 32'h8000_0000, 64'h55,                64'h0,                 1'b1, 1'b0, 0, 32'h0,         8'h00, 64'h0,                  64'h0,                 1'b1);
        xact("ld32",   1'b0, 1'b0, 3'b011, 32'h8000_0000, 64'h0,                 64'h0,                 1'b1, 1'b0, 0, 32'h0,         8'h00, 64'h0,                  64'h0,                 1'b1);
`ifdef YSYX_24100005_LSU_MISALIGN_TRAP_EN
        xact("lw_mis", 1'b0, 1'b0, 3'b010, 32'h8000_0001, 64'h0,                 64'h1122_3344,         1'b1, 1'b0, 0, 32'h0,         8'h00, 64'h0,                  64'h0,                 1'b1);
`else
        xact("lw_mis", 1'b0, 1'b0, 3'b010, 32'h8000_0001, 64'h0,                 64'h1122_3344,         1'b0, 1'b0, 0, 32'h8000_0000, 8'h00, 64'h0,                  64'h1122_3344,         1'b0);
`endif
        xact("lhu64",  1'b1, 1'b0, 3'b101, 32'h8000_0006, 64'h0,                 64'hBEEF_0000_0000_0000, 1'b0, 1'b0, 0, 32'h8000_0000, 8'h00, 64'h0,                64'h0000_0000_0000_BEEF, 1'b0);
        xact("sd64",   1'b1, 1'b1, 3'b011, 32'h8000_0008, 64'h0123_4567_89AB_CDEF, 64'h0,               1'b0, 1'b0, 0, 32'h8000_0008, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0,                 1'b0);
        xact("lw64",   1'b1, 1'b0, 3'b010, 32'h8000_0004, 64'h0,                 64'h8765_4321_0000_0000, 1'b0, 1'b0, 0, 32'h8000_0000, 8'h00, 64'h0,                64'hFFFF_FFFF_8765_4321, 1'b0);
        xact("lwu64",  1'b1, 1'b0, 3'b110, 32'h8000_0004, 64'h0,                 64'h8765_4321_0000_0000, 1'b0, 1'b0, 0, 32'h8000_0000, 8'h00, 64'h0,                64'h0000_0000_8765_4321, 1'b0);
        xact("ld64",   1'b1, 1'b0, 3'b011, 32'h8000_0010, 64'h0,                 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 0, 32'h8000_0010, 8'h00, 64'h0,                64'h0123_4567_89AB_CDEF, 1'b0);

        // Bus never accepts: five BUS cycles (counter 0..4), then an error response.
        sel = 1'b0;
        sb.push_back('{rdata: 64'h0, err: 1'b1});
        req_valid_32 = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8000_0010;
        step();
        req_valid_32 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("timeout", "mem_valid_held", 64'(o_mem_valid), 64'd1);
            chk("timeout", "mem_addr_held", 64'(o_mem_addr), 64'h8000_0010);
            chk("timeout", "no_resp_yet", 64'(o_resp_valid), 64'd0);
            step();
        end
        respond("timeout", 0);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h5555_5555;
        step();
        mem_rvalid = 1'b0;
        chk("late_rvalid", "resp_valid", 64'(o_resp_valid), 64'd0);
        chk("late_rvalid", "req_ready", 64'(o_req_ready), 64'd1);
        step();
        chk("late_rvalid", "resp_valid2", 64'(o_resp_valid), 64'd0);

        // Reset while waiting for completion.
        req_valid_32 = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8000_0020;
        step();
        req_valid_32 = 1'b0;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_wait", "mem_valid", 64'(o_mem_valid), 64'd0);
        chk("rst_wait", "resp_valid", 64'(o_resp_valid), 64'd0);
        chk("rst_wait", "req_ready", 64'(o_req_ready), 64'd1);
        chk("rst_wait", "mem_addr", 64'(o_mem_addr), 64'd0);
        #2 rst = 1'b0;
        xact("after_rst", 1'b0, 1'b0, 3'b010, 32'h8000_0020, 64'h0, 64'h7654_3210, 1'b0, 1'b0, 2, 32'h8000_0020, 8'h00, 64'h0, 64'h7654_3210, 1'b0);

        chk("end", "sb_left", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
